// File: rtl/operand_capture.sv
// Captures two 2-bit operands from slide switches on debounced load presses and
// presents them, with a valid flag, to the downstream magnitude comparator.
module operand_capture #(
    parameter int DB_CNT = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       btn_load,
    input  logic       btn_clear,
    output logic       a1,
    output logic       a0,
    output logic       b1,
    output logic       b0,
    output logic       valid,
    output logic       led_wait_a,
    output logic       led_wait_b
);

    localparam int CNT_W = $clog2(DB_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        SHOW   = 2'b10
    } state_t;

    logic [1:0]       sw_meta;
    logic [1:0]       sw_sync;
    logic             load_meta;
    logic             load_sync;
    logic             clear_meta;
    logic             clear_sync;
    logic             load_level;
    logic             clear_level;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] clear_cnt;
    logic             load_level_q;
    logic             load_pulse;
    logic [1:0]       a_reg;
    logic [1:0]       b_reg;
    logic             valid_reg;
    state_t           state;

    // Two-flop synchronisers for every asynchronous board input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta    <= 2'b00;
            sw_sync    <= 2'b00;
            load_meta  <= 1'b0;
            load_sync  <= 1'b0;
            clear_meta <= 1'b0;
            clear_sync <= 1'b0;
        end else begin
            sw_meta    <= sw;
            sw_sync    <= sw_meta;
            load_meta  <= btn_load;
            load_sync  <= load_meta;
            clear_meta <= btn_clear;
            clear_sync <= clear_meta;
        end
    end

    // A new level is accepted only after DB_CNT consecutive differing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_level <= 1'b0;
            load_cnt   <= '0;
        end else if (load_sync == load_level) begin
            load_cnt <= '0;
        end else if (load_cnt == CNT_LAST) begin
            load_level <= ~load_level;
            load_cnt   <= '0;
        end else begin
            load_cnt <= load_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_level <= 1'b0;
            clear_cnt   <= '0;
        end else if (clear_sync == clear_level) begin
            clear_cnt <= '0;
        end else if (clear_cnt == CNT_LAST) begin
            clear_level <= ~clear_level;
            clear_cnt   <= '0;
        end else begin
            clear_cnt <= clear_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_level_q <= 1'b0;
        end else begin
            load_level_q <= load_level;
        end
    end

    assign load_pulse = load_level & ~load_level_q;

    // Clear is level-sensitive and outranks a load pulse arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= 2'b00;
            b_reg     <= 2'b00;
            valid_reg <= 1'b0;
            state     <= WAIT_A;
        end else if (clear_level) begin
            a_reg     <= 2'b00;
            b_reg     <= 2'b00;
            valid_reg <= 1'b0;
            state     <= WAIT_A;
        end else begin
            case (state)
                WAIT_A: begin
                    if (load_pulse) begin
                        a_reg     <= sw_sync;
                        valid_reg <= 1'b0;
                        state     <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (load_pulse) begin
                        b_reg     <= sw_sync;
                        valid_reg <= 1'b1;
                        state     <= SHOW;
                    end
                end
                SHOW: begin
                    if (load_pulse) begin
                        a_reg     <= sw_sync;
                        valid_reg <= 1'b0;
                        state     <= WAIT_B;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

    assign a1         = a_reg[1];
    assign a0         = a_reg[0];
    assign b1         = b_reg[1];
    assign b0         = b_reg[0];
    assign valid      = valid_reg;
    assign led_wait_a = (state == WAIT_A);
    assign led_wait_b = (state == WAIT_B);

endmodule

// File: tb/tb_operand_capture.sv
// Directed bench for operand_capture: expected outputs are queued when a stimulus
// step is driven and popped when the step's outcome is sampled on the falling edge.
module tb_operand_capture;

    localparam int DB_CNT = 4;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic [1:0] sw        = 2'b00;
    logic       btn_load  = 1'b0;
    logic       btn_clear = 1'b0;
    logic       a1, a0, b1, b0, valid, led_wait_a, led_wait_b;

    operand_capture #(.DB_CNT(DB_CNT)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn_load   (btn_load),
        .btn_clear  (btn_clear),
        .a1         (a1),
        .a0         (a0),
        .b1         (b1),
        .b0         (b0),
        .valid      (valid),
        .led_wait_a (led_wait_a),
        .led_wait_b (led_wait_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] vec;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] m_a = 2'b00;
    logic [1:0] m_b = 2'b00;
    logic       m_valid = 1'b0;
    int         m_state = 0;

    // Model state: 0 = WAIT_A, 1 = WAIT_B, 2 = SHOW.
    function automatic logic [6:0] model_vec();
        return {m_a, m_b, m_valid, (m_state == 0), (m_state == 1)};
    endfunction

    task automatic model_load(input logic [1:0] v);
        case (m_state)
            0: begin m_a = v; m_valid = 1'b0; m_state = 1; end
            1: begin m_b = v; m_valid = 1'b1; m_state = 2; end
            default: begin m_a = v; m_valid = 1'b0; m_state = 1; end
        endcase
    endtask

    task automatic model_clear();
        m_a = 2'b00;
        m_b = 2'b00;
        m_valid = 1'b0;
        m_state = 0;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.vec = model_vec();
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t       e;
        logic [6:0] obs;
        obs = {a1, a0, b1, b0, valid, led_wait_a, led_wait_b};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_underflow: observed %b, no expected entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.vec) else begin
                errors++;
                $error("[TB] FAIL %s: observed {a,b,valid,wa,wb}=%b expected %b", e.tag, obs, e.vec);
            end
        end
    endtask

    // Clean press held for 'hold' edges; checks one edge before capture, at capture and after release.
    task automatic apply_stimulus(input logic [1:0] v, input int hold, input string tag);
        @(negedge clk);
        sw = v;
        btn_load = 1'b1;
        push_exp({tag, "_pre"});
        model_load(v);
        push_exp(tag);
        push_exp({tag, "_rel"});
        repeat (DB_CNT + 2) @(posedge clk);
        @(negedge clk);
        check_output();
        @(posedge clk);
        @(negedge clk);
        check_output();
        repeat (hold - DB_CNT - 3) @(posedge clk);
        @(negedge clk);
        btn_load = 1'b0;
        repeat (2 * DB_CNT + 4) @(posedge clk);
        @(negedge clk);
        check_output();
    endtask

    // Switch value present before edge k of the held press in the toggle test.
    function automatic logic [1:0] sw_pat(input int k);
        return 2'((k + 2) & 3);
    endfunction

    initial begin
        // Reset takes effect with no clock edge.
        #1 rst = 1'b1;
        model_clear();
        push_exp("reset_async");
        #1 check_output();
        @(negedge clk);
        rst = 1'b0;
        push_exp("reset_release");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output();

        apply_stimulus(2'b10, 20, "load_a");
        apply_stimulus(2'b01, 20, "load_b");

        // Bounce train shorter than the debounce window.
        @(negedge clk);
        sw = 2'b11;
        btn_load = 1'b1;
        push_exp("bounce");
        repeat (3) @(negedge clk);
        btn_load = 1'b0;
        repeat (2) @(negedge clk);
        btn_load = 1'b1;
        repeat (3) @(negedge clk);
        btn_load = 1'b0;
        repeat (12) @(negedge clk);
        check_output();

        // Long hold with switches toggling every cycle: the value synchronised
        // before edge 6 (driven before edge 5) is the one captured at edge 7.
        @(negedge clk);
        btn_load = 1'b1;
        sw = sw_pat(1);
        push_exp("hold_pre");
        model_load(sw_pat(5));
        push_exp("hold_capture");
        push_exp("hold_no_repeat");
        push_exp("hold_release");
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            sw = sw_pat(k + 1);
        end
        check_output();
        @(posedge clk);
        @(negedge clk);
        sw = sw_pat(8);
        check_output();
        for (int k = 8; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            sw = sw_pat(k + 1);
        end
        check_output();
        btn_load = 1'b0;
        sw = 2'b01;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_output();
        apply_stimulus(2'b01, 20, "repress_b");

        // From SHOW, a new load restarts A and drops valid while B is kept.
        apply_stimulus(2'b00, 20, "show_reload");

        // Clear and load pressed together: clear wins, load is dropped.
        @(negedge clk);
        sw = 2'b11;
        btn_load = 1'b1;
        btn_clear = 1'b1;
        push_exp("clr_pre");
        model_clear();
        push_exp("clr_apply");
        push_exp("clr_release");
        repeat (DB_CNT + 2) @(posedge clk);
        @(negedge clk);
        check_output();
        @(posedge clk);
        @(negedge clk);
        check_output();
        repeat (5) @(posedge clk);
        @(negedge clk);
        btn_load = 1'b0;
        btn_clear = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_output();
        apply_stimulus(2'b10, 20, "after_clear");

        // Mid-operation asynchronous reset.
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        push_exp("reset_mid");
        push_exp("reset_mid_release");
        #1 check_output();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output();

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
